sensor_gate_ctrl: RTL
=====================

SENSOR_GATE_CTRL -- requirements
Module: sensor_gate_ctrl

Parameters
REQ-001 The block SHALL have parameter N_SENS, default 10, giving the number of sensor/gate channels (1..32).
REQ-002 The block SHALL have parameter N_GRP, default 4, giving the number of programmable sensor-group detectors (1..8).
REQ-003 The block SHALL have parameter QUAL_CYC, default 4, giving the assert qualification length in cycles (1..255).
REQ-004 The block SHALL have parameter HOLD_CYC, default 8, giving the deassert hold length in cycles (1..255).

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the reset. The design uses one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port vdd, input, 1 bit: global gating enable. 0 forces all channels off.
REQ-008 The block SHALL have port sensor, input, N_SENS bits: per-channel request. It is synchronous to clk; synchronisation happens upstream.
REQ-009 The block SHALL have port grp_mask, input, N_GRP*N_SENS bits: slice g selects the members of group g. It is quasi-static.
REQ-010 The block SHALL have port isg, output, N_SENS bits: registered per-channel gate enable.
REQ-011 The block SHALL have port grp_act, output, N_GRP bits: registered flag meaning all members of group g are gated on.
REQ-012 The block SHALL have port act_cnt, output, clog2(N_SENS+1) bits: registered count of channels with isg=1.
REQ-013 The block SHALL have port chg, output, 1 bit: one-cycle pulse, 1 in the cycle after any isg bit changes.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, QUAL, ACTIVE and RELEASE, and an 8-bit counter cnt.
REQ-015 IDLE SHALL drive isg=0. If sensor=1, the channel goes to QUAL with cnt=0; otherwise it stays in IDLE.
REQ-016 QUAL SHALL drive isg=0. sensor=0 returns the channel to IDLE. sensor=1 with cnt==QUAL_CYC-1 goes to ACTIVE. sensor=1 otherwise stays in QUAL with cnt+1.
REQ-017 ACTIVE SHALL drive isg=1. If sensor=0, the channel goes to RELEASE with cnt=0; otherwise it stays in ACTIVE.
REQ-018 RELEASE SHALL drive isg=1. sensor=1 returns the channel to ACTIVE. sensor=0 with cnt==HOLD_CYC-1 goes to IDLE. sensor=0 otherwise stays in RELEASE with cnt+1.
REQ-019 isg SHALL be the registered decode of the channel state. isg rises on the (QUAL_CYC+1)th consecutive clock edge that samples sensor=1, and falls on the (HOLD_CYC+1)th consecutive edge that samples sensor=0.
REQ-020 When vdd=0 is sampled, every channel SHALL go to IDLE with cnt=0 on that edge, overriding sensor. isg is 0 from the next cycle, and grp_act and act_cnt follow one cycle later.
REQ-021 grp_act[g] SHALL be registered from the current isg register: 1 iff grp_mask slice g is nonzero and every masked isg bit is 1. An all-zero mask always gives 0.
REQ-022 act_cnt SHALL be registered as the population count of the isg register, giving one cycle of latency after isg. The count SHALL use full width with no saturation.
REQ-023 chg SHALL be registered as the OR of (isg XOR isg_prev), where isg_prev is a register. It pulses once per edge on which one or more channels change together.
REQ-024 A sensor pulse shorter than QUAL_CYC+1 cycles SHALL never assert isg. A dropout shorter than HOLD_CYC+1 cycles SHALL never deassert isg.
REQ-025 Channels SHALL be fully independent. Simultaneous transitions on any subset are legal and are all reflected in the same cycle.

Reset
REQ-026 While rst_n=0, immediately and independent of clk, the block SHALL hold all FSMs in IDLE with cnt=0, isg=0, isg_prev=0, grp_act=0, act_cnt=0 and chg=0.
REQ-027 Reset released mid-qualification or mid-hold SHALL restart the affected channel from IDLE. No partial count is retained.
REQ-028 The first state update after rst_n deasserts SHALL occur on the first rising clk edge.

Verification (N_SENS=10, N_GRP=4, QUAL_CYC=4, HOLD_CYC=8, vdd=1 unless stated)
REQ-029 Stimulus: sensor[3] held high for 5 edges. Required: isg[3]=1 after edge 5, act_cnt=1 and chg=1 one cycle later, chg=0 the following cycle.
REQ-030 Stimulus: sensor[3] high 4 edges, low 1, high 4. Required: isg[3] stays 0 throughout. Stimulus: isg[3]=1 with sensor[3] low 8 edges then high. Required: isg[3] stays 1.
REQ-031 Stimulus: grp_mask slice0=0x00E (channels 1-3), sensor=0x00E for 5 edges. Required: isg=0x00E, grp_act[0]=1 one cycle later, grp_act[1..3]=0 (masks zero). Stimulus: then sensor[2]=0 for 9 edges. Required: grp_act[0]=0.
REQ-032 Stimulus: sensor=0x3FF steady, isg=0x3FF, then vdd=0 for 1 cycle. Required: isg=0 next cycle, act_cnt=0 and chg=1 the cycle after. After vdd returns, isg is 0x3FF again after 5 edges.
REQ-033 Stimulus: rst_n asserted asynchronously mid-QUAL on channel 0 and mid-RELEASE on channel 9. Required: all outputs 0 without waiting for a clk edge. With sensor held high after release, isg[0] rises after exactly 5 edges.

Source files
------------

// File: rtl/sensor_gate_ctrl.sv
// Per-channel sensor qualification and gate control with hysteresis,
// plus group-active detection, active-channel count and change pulse.
module sensor_gate_ctrl #(
  parameter  int N_SENS   = 10,
  parameter  int N_GRP    = 4,
  parameter  int QUAL_CYC = 4,
  parameter  int HOLD_CYC = 8,
  localparam int CNT_W    = $clog2(N_SENS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vdd,
  input  logic [N_SENS-1:0]       sensor,
  input  logic [N_GRP*N_SENS-1:0] grp_mask,
  output logic [N_SENS-1:0]       isg,
  output logic [N_GRP-1:0]        grp_act,
  output logic [CNT_W-1:0]        act_cnt,
  output logic                    chg
);

  // State bit 1 is the gate enable, so isg comes straight off a flop.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_QUAL    = 2'b01;
  localparam logic [1:0] ST_ACTIVE  = 2'b10;
  localparam logic [1:0] ST_RELEASE = 2'b11;

  localparam logic [7:0] QUAL_LAST = 8'(QUAL_CYC - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  logic [1:0]        state_p0  [N_SENS];
  logic [1:0]        state_nxt [N_SENS];
  logic [7:0]        cnt_p0    [N_SENS];
  logic [7:0]        cnt_nxt   [N_SENS];
  logic [N_SENS-1:0] isg_p1;
  logic [N_GRP-1:0]  grp_nxt;
  logic [CNT_W-1:0]  pop;

  always_comb begin
    for (int i = 0; i < N_SENS; i++) begin
      state_nxt[i] = state_p0[i];
      cnt_nxt[i]   = cnt_p0[i];
      if (!vdd) begin
        state_nxt[i] = ST_IDLE;
        cnt_nxt[i]   = '0;
      end else begin
        case (state_p0[i])
          ST_IDLE: begin
            if (sensor[i]) begin
              state_nxt[i] = ST_QUAL;
              cnt_nxt[i]   = '0;
            end
          end
          ST_QUAL: begin
            if (!sensor[i]) begin
              state_nxt[i] = ST_IDLE;
              cnt_nxt[i]   = '0;
            end else if (cnt_p0[i] == QUAL_LAST) begin
              state_nxt[i] = ST_ACTIVE;
              cnt_nxt[i]   = '0;
            end else begin
              cnt_nxt[i] = cnt_p0[i] + 8'd1;
            end
          end
          ST_ACTIVE: begin
            if (!sensor[i]) begin
              state_nxt[i] = ST_RELEASE;
              cnt_nxt[i]   = '0;
            end
          end
          default: begin
            if (sensor[i]) begin
              state_nxt[i] = ST_ACTIVE;
              cnt_nxt[i]   = '0;
            end else if (cnt_p0[i] == HOLD_LAST) begin
              state_nxt[i] = ST_IDLE;
              cnt_nxt[i]   = '0;
            end else begin
              cnt_nxt[i] = cnt_p0[i] + 8'd1;
            end
          end
        endcase
      end
    end
  end

  // Stage p0: channel FSMs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SENS; i++) begin
        state_p0[i] <= ST_IDLE;
        cnt_p0[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_SENS; i++) begin
        state_p0[i] <= state_nxt[i];
        cnt_p0[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SENS; i++) begin
      isg[i] = state_p0[i][1];
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SENS; i++) begin
      pop = pop + CNT_W'(isg[i]);
    end
  end

  // An empty mask must never report the group as active.
  always_comb begin
    for (int g = 0; g < N_GRP; g++) begin
      grp_nxt[g] = (|grp_mask[g*N_SENS +: N_SENS]) &&
                   ((isg & grp_mask[g*N_SENS +: N_SENS]) == grp_mask[g*N_SENS +: N_SENS]);
    end
  end

  // Stage p1: summary flags derived from the gate register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isg_p1  <= '0;
      grp_act <= '0;
      act_cnt <= '0;
      chg     <= 1'b0;
    end else begin
      isg_p1  <= isg;
      grp_act <= grp_nxt;
      act_cnt <= pop;
      chg     <= |(isg ^ isg_p1);
    end
  end

endmodule
